// File: rtl/ibex_multdiv_iter_if.sv
// Request/response bundle between the execute stage and ibex_multdiv_iter.
// The unit takes the slave side; the execute-stage requester is the master.
interface ibex_multdiv_iter_if;
  logic        en_i;
  logic [1:0]  operator_i;
  logic [1:0]  signed_mode_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic [31:0] result_o;
  logic        valid_o;

  modport master (
    output en_i, operator_i, signed_mode_i, op_a_i, op_b_i,
    input  result_o, valid_o
  );

  modport slave (
    input  en_i, operator_i, signed_mode_i, op_a_i, op_b_i,
    output result_o, valid_o
  );
endinterface

// File: rtl/ibex_multdiv_iter.sv
// Iterative RV32M mul/div unit borrowing the ALU adder; fixed 36-cycle latency.
// Optional IBEX_MULTDIV_DIV0_FAST_EN: divide-by-zero completes in one cycle.
module ibex_multdiv_iter (
  input  logic               clk_i,
  input  logic               rst_ni,
  ibex_multdiv_iter_if.slave md,
  input  logic [33:0]        alu_adder_ext_i,
  output logic [32:0]        alu_operand_a_o,
  output logic [32:0]        alu_operand_b_o,
  output logic               multdiv_en_o
);

  typedef enum logic [2:0] {
    IDLE,
    ABS_A,
    ABS_B,
    COMP,
    CHANGE_SIGN,
    FINISH
  } state_e;

  localparam logic [1:0] OP_REM = 2'd3;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic        neg_q, neg_d;
  logic        div0_q, div0_d;
  logic        valid_q, valid_d;

  logic [32:0] opa, opb;
  logic [31:0] rem_sh;
  logic [31:0] addend;
  logic [31:0] sgn_src;
  logic [31:0] ext_res;
  logic [32:0] sum33;
  logic        keep;
  logic        unused_ext0;

  assign ext_res     = alu_adder_ext_i[32:1];
  assign sum33       = alu_adder_ext_i[33:1];
  assign unused_ext0 = alu_adder_ext_i[0];

  assign rem_sh  = {acc_q[30:0], lo_q[31]};
  assign addend  = b_q[0] ? a_q : 32'd0;
  assign sgn_src = (op_q == OP_REM) ? acc_q : lo_q;
  // Shifted-out remainder bit means the true value already exceeds the divisor.
  assign keep    = alu_adder_ext_i[33] | acc_q[31];

  always_comb begin
    opa = '0;
    opb = '0;
    case (state_q)
      ABS_A: begin
        if (sa_q && !div0_q) begin
          opa = {32'd0, 1'b1};
          opb = {~a_q, 1'b1};
        end
      end
      ABS_B: begin
        if (sb_q) begin
          opa = {32'd0, 1'b1};
          opb = {~b_q, 1'b1};
        end
      end
      COMP: begin
        if (op_q[1]) begin
          opa = {rem_sh, 1'b1};
          opb = {~b_q, 1'b1};
        end else begin
          opa = {acc_q, 1'b0};
          opb = {addend, 1'b0};
        end
      end
      CHANGE_SIGN: begin
        if (neg_q && !div0_q) begin
          opa = {32'd0, 1'b1};
          opb = {~sgn_src, 1'b1};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    neg_d   = neg_q;
    div0_d  = div0_q;
    valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (md.en_i) begin
          op_d    = md.operator_i;
          a_d     = md.op_a_i;
          b_d     = md.op_b_i;
          acc_d   = '0;
          lo_d    = '0;
          cnt_d   = 5'd31;
          sa_d    = md.signed_mode_i[0] & md.op_a_i[31];
          sb_d    = md.signed_mode_i[1] & md.op_b_i[31];
          neg_d   = (md.operator_i == OP_REM) ? sa_d : (sa_d ^ sb_d);
          div0_d  = md.operator_i[1] & (md.op_b_i == '0);
          state_d = ABS_A;
`ifdef IBEX_MULTDIV_DIV0_FAST_EN
          if (div0_d) begin
            state_d = FINISH;
            valid_d = 1'b1;
            res_d   = (md.operator_i == OP_REM) ? md.op_a_i : 32'hFFFF_FFFF;
          end
`endif
        end
      end
      ABS_A: begin
        // Divide by zero keeps the raw dividend so the remainder equals op_a.
        if (sa_q && !div0_q) begin
          a_d = ext_res;
        end
        if (op_q[1]) begin
          lo_d = a_d;
        end
        state_d = ABS_B;
      end
      ABS_B: begin
        if (sb_q) begin
          b_d = ext_res;
        end
        state_d = COMP;
      end
      COMP: begin
        if (op_q[1]) begin
          acc_d = keep ? ext_res : rem_sh;
          lo_d  = {lo_q[30:0], keep};
        end else begin
          acc_d = sum33[32:1];
          lo_d  = {sum33[0], lo_q[31:1]};
          b_d   = {1'b0, b_q[31:1]};
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d = CHANGE_SIGN;
        end
      end
      CHANGE_SIGN: begin
        if (neg_q && !div0_q) begin
          if (op_q == OP_REM) begin
            acc_d = ext_res;
          end else begin
            lo_d = ext_res;
          end
          if (!op_q[1]) begin
            acc_d = ~acc_q + {31'd0, (lo_q == '0)};
          end
        end
        res_d   = op_q[0] ? acc_d : lo_d;
        valid_d = 1'b1;
        state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_q != IDLE && !md.en_i) begin
      state_d = IDLE;
      valid_d = 1'b0;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      neg_q   <= 1'b0;
      div0_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      neg_q   <= neg_d;
      div0_q  <= div0_d;
      valid_q <= valid_d;
    end
  end

  assign alu_operand_a_o = opa;
  assign alu_operand_b_o = opb;
  assign multdiv_en_o    = (state_q == ABS_A) || (state_q == ABS_B) ||
                           (state_q == COMP)  || (state_q == CHANGE_SIGN);
  assign md.result_o     = res_q;
  assign md.valid_o      = valid_q;

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Self-checking bench for ibex_multdiv_iter with a behavioural ALU adder.
// Honours IBEX_MULTDIV_DIV0_FAST_EN for the divide-by-zero latency.
module tb_ibex_multdiv_iter;

  logic        clk;
  logic        rst_ni;
  logic [33:0] ext;
  logic [32:0] opa;
  logic [32:0] opb;
  logic        mden;

  ibex_multdiv_iter_if mdif ();

  ibex_multdiv_iter dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .md              (mdif.slave),
    .alu_adder_ext_i (ext),
    .alu_operand_a_o (opa),
    .alu_operand_b_o (opb),
    .multdiv_en_o    (mden)
  );

  assign ext = {1'b0, opa} + {1'b0, opb};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  sm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [15];
  logic [31:0] sb_q [$];
  int          n_chk;
  int          n_fail;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op,
                                        input logic [1:0] sm,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint      x, y;
    logic [63:0] p;
    x = sm[0] ? longint'($signed(a)) : longint'(a);
    y = sm[1] ? longint'($signed(b)) : longint'(b);
    case (op)
      2'd0: begin p = 64'(x * y); return p[31:0]; end
      2'd1: begin p = 64'(x * y); return p[63:32]; end
      2'd2: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = 64'(x / y);
        return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = 64'(x % y);
        return p[31:0];
      end
    endcase
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [1:0] sm,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] req, input string name);
    int          cyc;
    int          en_cnt;
    int          lat;
    bit          seen;
    logic [31:0] e;
    lat = 36;
`ifdef IBEX_MULTDIV_DIV0_FAST_EN
    if (op[1] && b == 32'd0) lat = 1;
`endif
    @(negedge clk);
    mdif.en_i          = 1'b1;
    mdif.operator_i    = op;
    mdif.signed_mode_i = sm;
    mdif.op_a_i        = a;
    mdif.op_b_i        = b;
    sb_q.push_back(req);
    cyc    = 0;
    en_cnt = 0;
    seen   = 1'b0;
    while (!seen && cyc < 80) begin
      @(posedge clk);
      #1;
      cyc++;
      if (mden) en_cnt++;
      if (mdif.valid_o) seen = 1'b1;
    end
    e = sb_q.pop_front();
    check({name, "/latency"}, 32'(cyc), 32'(lat));
    check({name, "/result"}, mdif.result_o, e);
    check({name, "/adder_cycles"}, 32'(en_cnt), (lat == 1) ? 32'd0 : 32'd35);
    @(posedge clk);
    #1;
    mdif.en_i = 1'b0;
    check({name, "/pulse_width"}, {31'd0, mdif.valid_o}, 32'd0);
  endtask

  initial begin
    int          vld_cnt;
    logic [1:0]  rop;
    logic [1:0]  rsm;
    logic [31:0] ra;
    logic [31:0] rb;

    n_chk  = 0;
    n_fail = 0;
    vecs[0]  = '{2'd0, 2'd3, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{2'd1, 2'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{2'd1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3]  = '{2'd2, 2'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
    vecs[4]  = '{2'd3, 2'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    vecs[5]  = '{2'd2, 2'd3, 32'd5,         32'd0,         32'hFFFF_FFFF};
    vecs[6]  = '{2'd3, 2'd3, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9};
    vecs[7]  = '{2'd2, 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[8]  = '{2'd3, 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[9]  = '{2'd1, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[10] = '{2'd3, 2'd0, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9};
    vecs[11] = '{2'd2, 2'd0, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC};
    vecs[12] = '{2'd0, 2'd0, 32'h1234_5678, 32'h10,        32'h2345_6780};
    vecs[13] = '{2'd3, 2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1};
    vecs[14] = '{2'd2, 2'd3, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2};

    rst_ni             = 1'b0;
    mdif.en_i          = 1'b0;
    mdif.operator_i    = 2'd0;
    mdif.signed_mode_i = 2'd0;
    mdif.op_a_i        = 32'd0;
    mdif.op_b_i        = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/valid", {31'd0, mdif.valid_o}, 32'd0);
    check("reset/result", mdif.result_o, 32'd0);
    check("reset/mden", {31'd0, mden}, 32'd0);
    check("reset/opa", opa[31:0], 32'd0);
    check("reset/opb", opb[31:0], 32'd0);
    rst_ni = 1'b1;

    for (int i = 0; i < 15; i++) begin
      do_op(vecs[i].op, vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].exp,
            $sformatf("vec%0d", i));
    end

    // Abort: drop en_i in cycle 10 of a MUL.
    @(negedge clk);
    mdif.en_i          = 1'b1;
    mdif.operator_i    = 2'd0;
    mdif.signed_mode_i = 2'd0;
    mdif.op_a_i        = 32'd9;
    mdif.op_b_i        = 32'd9;
    vld_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (mdif.valid_o) vld_cnt++;
    end
    check("abort/mden_c10", {31'd0, mden}, 32'd1);
    mdif.en_i = 1'b0;
    @(posedge clk);
    #1;
    if (mdif.valid_o) vld_cnt++;
    check("abort/mden_c11", {31'd0, mden}, 32'd0);
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (mdif.valid_o) vld_cnt++;
    end
    check("abort/no_valid", 32'(vld_cnt), 32'd0);
    do_op(2'd2, 2'd0, 32'd100, 32'd7, 32'd14, "div100_7");

    for (int i = 0; i < 10; i++) begin
      rop = 2'($urandom_range(0, 3));
      rsm = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 4) ? 32'd0 : $urandom;
      do_op(rop, rsm, ra, rb, model(rop, rsm, ra, rb),
            $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a DIV.
    @(negedge clk);
    mdif.en_i          = 1'b1;
    mdif.operator_i    = 2'd2;
    mdif.signed_mode_i = 2'd0;
    mdif.op_a_i        = 32'd4096;
    mdif.op_b_i        = 32'd3;
    repeat (20) @(posedge clk);
    #1;
    rst_ni    = 1'b0;
    mdif.en_i = 1'b0;
    @(posedge clk);
    #1;
    check("midrst/valid", {31'd0, mdif.valid_o}, 32'd0);
    check("midrst/result", mdif.result_o, 32'd0);
    check("midrst/mden", {31'd0, mden}, 32'd0);
    check("midrst/opa", opa[31:0], 32'd0);
    check("midrst/opb", opb[31:0], 32'd0);
    rst_ni  = 1'b1;
    vld_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (mdif.valid_o) vld_cnt++;
    end
    check("midrst/no_valid", 32'(vld_cnt), 32'd0);
    do_op(2'd0, 2'd3, 32'd3, 32'd5, 32'd15, "post_reset_mul");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
